// File: rtl/scroll_ctrl.sv
// -----------------------------------------------------------------------------
// scroll_ctrl
//
// Turns the slide-switch scroll controls into a horizontal scroll offset for
// the pixel-address generator, which adds `offset` to the halved h_cnt modulo
// WIDTH. The offset only moves at frame boundaries (taken from the falling
// edge of vsync), so a frame never shows a tear.
//
// Parameters
//   WIDTH      image width in source pixels (16..512); offset is 0..WIDTH-1
//   FRAME_DIV  frames per scroll step (1..64)
//
// Ports
//   clk        in   pixel clock (shared with the VGA controller)
//   rst        in   asynchronous reset, active low
//   en         in   scroll enable switch (asynchronous)
//   dir        in   direction switch: 0 = offset increases, 1 = decreases
//   speed[2:0] in   step size minus one (step = speed+1)
//   vsync      in   active-low vertical sync, synchronous to clk
//   offset[8:0] out registered scroll offset
//   frame_tick  out one-cycle pulse per frame
//   dir_eff     out direction applied on the last or next step
//
// Build option
//   SCROLL_BOUNCE_EN  when defined the offset bounces off the image edges
//                     instead of wrapping; dir_eff then holds the bounce
//                     direction and reloads from the switch on any change.
// -----------------------------------------------------------------------------
module scroll_ctrl #(
   parameter int WIDTH     = 320,
   parameter int FRAME_DIV = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic       dir,
   input  logic [2:0] speed,
   input  logic       vsync,
   output logic [8:0] offset,
   output logic       frame_tick,
   output logic       dir_eff
);

   localparam int CW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(FRAME_DIV - 1);
   localparam logic [9:0]    W10      = 10'(WIDTH);
   localparam logic [9:0]    W_MAX    = 10'(WIDTH - 1);

   typedef enum logic {
      IDLE,
      RUN
   } state_t;

   // two-flop synchronisers for the switch inputs
   logic       en_m,  en_s;
   logic       dir_m, dir_s;
   logic [2:0] speed_m, speed_s;

   logic       vs_d;

   state_t          state_q, state_n;
   logic [CW-1:0]   cnt_q, cnt_n;
   logic            step_go;

   logic [9:0]      step10;
   logic [9:0]      off10;
   logic [9:0]      fwd_sum;
   logic [9:0]      bwd_val;
   logic            use_dir;
   logic [8:0]      offset_n;
   logic            dir_eff_n;

`ifdef SCROLL_BOUNCE_EN
   logic            dir_s_d;
`endif

   // -----------------------------------------------------------------------
   // Frame sequencing: count ticks in RUN, fire a step every FRAME_DIV ticks.
   // Dropping enable (even on a tick cycle) abandons the partial count.
   // -----------------------------------------------------------------------
   always_comb begin
      state_n = state_q;
      cnt_n   = cnt_q;
      step_go = 1'b0;
      case (state_q)
         IDLE: begin
            cnt_n = '0;
            if (en_s) state_n = RUN;
         end
         RUN: begin
            if (!en_s) begin
               state_n = IDLE;
               cnt_n   = '0;
            end else if (frame_tick) begin
               if (cnt_q == CNT_LAST) begin
                  cnt_n   = '0;
                  step_go = 1'b1;
               end else begin
                  cnt_n = cnt_q + CW'(1);
               end
            end
         end
         default: begin
            state_n = IDLE;
            cnt_n   = '0;
         end
      endcase
   end

   // -----------------------------------------------------------------------
   // Step datapath. All arithmetic is 10 bits wide so offset+step and
   // offset+WIDTH-step never overflow before the range correction.
   // -----------------------------------------------------------------------
   always_comb begin
      step10  = {7'd0, speed_s} + 10'd1;
      off10   = {1'b0, offset};
      fwd_sum = off10 + step10;
      bwd_val = off10 - step10;

`ifdef SCROLL_BOUNCE_EN
      // a switch change overrides the bounce direction, even on a step edge
      use_dir = (dir_s != dir_s_d) ? dir_s : dir_eff;
`else
      use_dir = dir_s;
`endif

      offset_n  = offset;
      dir_eff_n = use_dir;

      if (step_go) begin
         if (!use_dir) begin
`ifdef SCROLL_BOUNCE_EN
            if (fwd_sum > W_MAX) begin
               offset_n  = W_MAX[8:0];
               dir_eff_n = 1'b1;
            end else begin
               offset_n = fwd_sum[8:0];
            end
`else
            if (fwd_sum >= W10) begin
               bwd_val  = fwd_sum - W10;
               offset_n = bwd_val[8:0];
            end else begin
               offset_n = fwd_sum[8:0];
            end
`endif
         end else begin
`ifdef SCROLL_BOUNCE_EN
            if (off10 < step10) begin
               offset_n  = '0;
               dir_eff_n = 1'b0;
            end else begin
               offset_n = bwd_val[8:0];
            end
`else
            if (off10 < step10) begin
               bwd_val  = off10 + W10 - step10;
               offset_n = bwd_val[8:0];
            end else begin
               offset_n = bwd_val[8:0];
            end
`endif
         end
      end
   end

   // -----------------------------------------------------------------------
   // Registers
   // -----------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         en_m       <= 1'b0;
         en_s       <= 1'b0;
         dir_m      <= 1'b0;
         dir_s      <= 1'b0;
         speed_m    <= '0;
         speed_s    <= '0;
         vs_d       <= 1'b1;
         frame_tick <= 1'b0;
         state_q    <= IDLE;
         cnt_q      <= '0;
         offset     <= '0;
         dir_eff    <= 1'b0;
`ifdef SCROLL_BOUNCE_EN
         dir_s_d    <= 1'b0;
`endif
      end else begin
         en_m       <= en;
         en_s       <= en_m;
         dir_m      <= dir;
         dir_s      <= dir_m;
         speed_m    <= speed;
         speed_s    <= speed_m;
         vs_d       <= vsync;
         // one pulse per vsync falling edge, however long the low phase
         frame_tick <= vs_d & ~vsync;
         state_q    <= state_n;
         cnt_q      <= cnt_n;
         offset     <= offset_n;
         dir_eff    <= dir_eff_n;
`ifdef SCROLL_BOUNCE_EN
         dir_s_d    <= dir_s;
`endif
      end
   end

endmodule
